// File: rtl/al_pkg.sv
// Shared allocation-stage types and constants for physical register handling.
package al_pkg;

  localparam int PREG_W   = 6;
  localparam int AL_LANES = 4;

  typedef logic [PREG_W-1:0] preg_t;

  // Preg 0 is the hardwired zero mapping and never circulates through the free list.
  localparam preg_t PREG_ZERO = 6'd0;

endpackage

// File: rtl/preg_lane_compact.sv
// Combinational 4-lane filter and pack: drops invalid lanes and the zero preg,
// then packs the survivors in ascending lane order.
module preg_lane_compact
  import al_pkg::*;
(
  input  logic  [AL_LANES-1:0] vld,
  input  preg_t [AL_LANES-1:0] preg,
  output preg_t [AL_LANES-1:0] packed_preg,
  output logic  [2:0]          push_cnt
);

  logic [2:0] idx_s;

  // Walk lanes in order, appending each surviving preg at the next free slot.
  always_comb begin
    packed_preg = '0;
    idx_s       = 3'd0;
    for (int i = 0; i < AL_LANES; i++) begin
      if (vld[i] && (preg[i] != PREG_ZERO)) begin
        packed_preg[idx_s[1:0]] = preg[i];
        idx_s                   = idx_s + 3'd1;
      end else begin
        idx_s = idx_s;
      end
    end
    push_cnt = idx_s;
  end

endmodule

// File: rtl/preg_release_q.sv
// Release queue returning retired pregs from commit to the free list.
// Optional same-cycle bypass on an empty queue: define PRQ_BYPASS_EN.
module preg_release_q
  import al_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        cmt_vld_in,
  input  logic [PREG_W-1:0] cmt_preg_in0,
  input  logic [PREG_W-1:0] cmt_preg_in1,
  input  logic [PREG_W-1:0] cmt_preg_in2,
  input  logic [PREG_W-1:0] cmt_preg_in3,
  input  logic              fl_stall_in,
  output logic [PREG_W-1:0] free_pr_out0,
  output logic [PREG_W-1:0] free_pr_out1,
  output logic [PREG_W-1:0] free_pr_out2,
  output logic [PREG_W-1:0] free_pr_out3,
  output logic [2:0]        free_pr_num_out,
  output logic              cmt_rdy_out,
  output logic              ovfl_err_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int SP_W  = CNT_W + 1;

  preg_t                 mem_r [DEPTH];
  logic  [PTR_W-1:0]     wr_ptr_r;
  logic  [PTR_W-1:0]     rd_ptr_r;
  logic  [CNT_W-1:0]     count_r;
  logic                  ovfl_r;

  preg_t [AL_LANES-1:0]  cmt_preg_s;
  preg_t [AL_LANES-1:0]  packed_s;
  preg_t [AL_LANES-1:0]  free_s;
  logic  [2:0]           push_cnt_s;
  logic  [2:0]           avail_s;
  logic  [2:0]           pop_cnt_s;
  logic  [2:0]           fifo_pop_s;
  logic  [2:0]           accept_s;
  logic  [SP_W-1:0]      space_s;
  logic                  bypass_s;
  logic                  ovfl_set_s;

  assign cmt_preg_s = {cmt_preg_in3, cmt_preg_in2, cmt_preg_in1, cmt_preg_in0};

  preg_lane_compact u_compact (
    .vld         (cmt_vld_in),
    .preg        (cmt_preg_s),
    .packed_preg (packed_s),
    .push_cnt    (push_cnt_s)
  );

`ifdef PRQ_BYPASS_EN
  assign bypass_s = (count_r == CNT_W'(0)) && !fl_stall_in;
`else
  assign bypass_s = 1'b0;
`endif

  // Pop selection, push acceptance against remaining space, and release slot muxing.
  always_comb begin
    avail_s = (count_r >= CNT_W'(4)) ? 3'd4 : count_r[2:0];
    if (fl_stall_in) begin
      pop_cnt_s = 3'd0;
    end else if (bypass_s) begin
      pop_cnt_s = push_cnt_s;
    end else begin
      pop_cnt_s = avail_s;
    end
    fifo_pop_s = bypass_s ? 3'd0 : pop_cnt_s;
    space_s    = SP_W'(DEPTH) - SP_W'(count_r) + SP_W'(fifo_pop_s);
    if (bypass_s) begin
      accept_s   = 3'd0;
      ovfl_set_s = 1'b0;
    end else if (SP_W'(push_cnt_s) > space_s) begin
      accept_s   = space_s[2:0];
      ovfl_set_s = 1'b1;
    end else begin
      accept_s   = push_cnt_s;
      ovfl_set_s = 1'b0;
    end
    free_s = '0;
    for (int k = 0; k < AL_LANES; k++) begin
      if (3'(k) < pop_cnt_s) begin
        free_s[k] = bypass_s ? packed_s[k] : mem_r[rd_ptr_r + PTR_W'(k)];
      end else begin
        free_s[k] = PREG_ZERO;
      end
    end
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      ovfl_r   <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(accept_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(fifo_pop_s);
      count_r  <= count_r + CNT_W'(accept_s) - CNT_W'(fifo_pop_s);
      ovfl_r   <= ovfl_r | ovfl_set_s;
    end
  end

  // Storage writes; contents are qualified by count so no reset is needed.
  always_ff @(posedge clk) begin
    for (int k = 0; k < AL_LANES; k++) begin
      if (3'(k) < accept_s) begin
        mem_r[wr_ptr_r + PTR_W'(k)] <= packed_s[k];
      end
    end
  end

  assign free_pr_out0    = free_s[0];
  assign free_pr_out1    = free_s[1];
  assign free_pr_out2    = free_s[2];
  assign free_pr_out3    = free_s[3];
  assign free_pr_num_out = pop_cnt_s;
  assign cmt_rdy_out     = (CNT_W'(DEPTH) - count_r) >= CNT_W'(4);
  assign ovfl_err_out    = ovfl_r;

endmodule
